// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB master bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int DEFAULT_ADDR_WIDTH     = 32;
  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response channel plus APB bus signals seen by the bridge.
interface apb_master_bridge_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  // The bridge itself.
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  // The requester plus the APB slave.
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding command to APB master bridge with wait-state timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic                 PCLK,
  input logic                 PRESETn,
  apb_master_bridge_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  assign bus.cmd_ready = (state == IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      bus.PSEL        <= 1'b0;
      bus.PENABLE     <= 1'b0;
      bus.PWRITE      <= 1'b0;
      bus.PADDR       <= ADDR_ZERO;
      bus.PWDATA      <= DATA_ZERO;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= DATA_ZERO;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.PWRITE <= bus.cmd_write;
            bus.PADDR  <= bus.cmd_addr;
            bus.PWDATA <= bus.cmd_wdata;
            if (bus.cmd_addr[1:0] == 2'b00) begin
              state    <= SETUP;
              wait_cnt <= '0;
              bus.PSEL <= 1'b1;
            end else begin
              // Misaligned: answer with an error without touching the bus.
              state           <= RESP;
              bus.rsp_valid   <= 1'b1;
              bus.rsp_err     <= 1'b1;
              bus.rsp_timeout <= 1'b0;
              bus.rsp_rdata   <= DATA_ZERO;
            end
          end
        end
        SETUP: begin
          state       <= ACCESS;
          bus.PENABLE <= 1'b1;
        end
        ACCESS: begin
          // PREADY is checked first so a late completion beats the timeout.
          if (bus.PREADY) begin
            state           <= RESP;
            bus.PSEL        <= 1'b0;
            bus.PENABLE     <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_err     <= bus.PSLVERR;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_rdata   <= (!bus.PWRITE && !bus.PSLVERR) ? bus.PRDATA : DATA_ZERO;
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
            if (wait_cnt == CNT_LAST) begin
              state           <= RESP;
              bus.PSEL        <= 1'b0;
              bus.PENABLE     <= 1'b0;
              bus.rsp_valid   <= 1'b1;
              bus.rsp_err     <= 1'b1;
              bus.rsp_timeout <= 1'b1;
              bus.rsp_rdata   <= DATA_ZERO;
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state           <= IDLE;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: reads, writes, wait states, errors, timeout and reset abort.
module tb_apb_master_bridge;
  import apb_pkg::*;

  logic PCLK;
  logic PRESETn;
  int   num_checks;
  int   num_fail;
  int   acc_cycles;

  apb_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_master_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .bus(bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    num_checks++;
    assert (observed === expected)
    else begin
      num_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present one command for a single accepting edge, then withdraw it.
  task automatic apply_stimulus(input logic write, input logic [31:0] addr,
                                input logic [31:0] wdata);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = write;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    check_output("cmd_ready_before_accept", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic finish_response();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check_output("rsp_valid_cleared", 32'(bus.rsp_valid), 32'd0);
    check_output("cmd_ready_after_rsp", 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    num_checks    = 0;
    num_fail      = 0;
    PRESETn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;

    repeat (2) tick();
    check_output("reset_psel", 32'(bus.PSEL), 32'd0);
    check_output("reset_penable", 32'(bus.PENABLE), 32'd0);
    check_output("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("reset_paddr", bus.PADDR, 32'h0);
    check_output("reset_pwdata", bus.PWDATA, 32'h0);
    check_output("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    PRESETn = 1'b1;
    tick();

    // Zero-wait read of 0x4.
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h0000_00A5;
    apply_stimulus(1'b0, 32'h0000_0004, 32'h0);
    check_output("rd_setup_psel", 32'(bus.PSEL), 32'd1);
    check_output("rd_setup_penable", 32'(bus.PENABLE), 32'd0);
    check_output("rd_setup_paddr", bus.PADDR, 32'h0000_0004);
    check_output("rd_setup_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    check_output("rd_access_psel", 32'(bus.PSEL), 32'd1);
    check_output("rd_access_penable", 32'(bus.PENABLE), 32'd1);
    check_output("rd_access_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    check_output("rd_resp_valid", 32'(bus.rsp_valid), 32'd1);
    check_output("rd_resp_rdata", bus.rsp_rdata, 32'h0000_00A5);
    check_output("rd_resp_err", 32'(bus.rsp_err), 32'd0);
    check_output("rd_resp_psel", 32'(bus.PSEL), 32'd0);
    finish_response();

    // Write with three wait states; read data on the bus must not leak into the response.
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'hDEAD_BEEF;
    apply_stimulus(1'b1, 32'h0000_0008, 32'h0000_0005);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.PREADY = 1'b1;
      check_output("wr_wait_psel", 32'(bus.PSEL), 32'd1);
      check_output("wr_wait_penable", 32'(bus.PENABLE), 32'd1);
      check_output("wr_wait_pwdata", bus.PWDATA, 32'h0000_0005);
      check_output("wr_wait_pwrite", 32'(bus.PWRITE), 32'd1);
      check_output("wr_wait_paddr", bus.PADDR, 32'h0000_0008);
      tick();
    end
    check_output("wr_resp_valid", 32'(bus.rsp_valid), 32'd1);
    check_output("wr_resp_rdata", bus.rsp_rdata, 32'h0);
    check_output("wr_resp_err", 32'(bus.rsp_err), 32'd0);
    check_output("wr_resp_psel", 32'(bus.PSEL), 32'd0);
    check_output("wr_hold_pwdata", bus.PWDATA, 32'h0000_0005);
    finish_response();

    // Slave error on a read.
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 32'h1111_2222;
    apply_stimulus(1'b0, 32'h1000_0010, 32'h0);
    check_output("slverr_paddr", bus.PADDR, 32'h1000_0010);
    repeat (2) tick();
    check_output("slverr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check_output("slverr_rsp_err", 32'(bus.rsp_err), 32'd1);
    check_output("slverr_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    check_output("slverr_rsp_rdata", bus.rsp_rdata, 32'h0);
    finish_response();
    bus.PSLVERR = 1'b0;

    // Slave never ready: abort after exactly 16 access cycles.
    bus.PREADY = 1'b0;
    acc_cycles = 0;
    apply_stimulus(1'b0, 32'h0000_0020, 32'h0);
    for (int i = 0; i < 40 && !bus.rsp_valid; i++) begin
      tick();
      if (bus.PSEL && bus.PENABLE) acc_cycles++;
    end
    check_output("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check_output("to_access_cycles", 32'(acc_cycles), 32'd16);
    check_output("to_rsp_err", 32'(bus.rsp_err), 32'd1);
    check_output("to_rsp_timeout", 32'(bus.rsp_timeout), 32'd1);
    check_output("to_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_output("to_psel", 32'(bus.PSEL), 32'd0);
    finish_response();
    check_output("to_timeout_cleared", 32'(bus.rsp_timeout), 32'd0);

    // PREADY arriving in the 16th access cycle completes normally.
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h5A5A_5A5A;
    apply_stimulus(1'b0, 32'h0000_0024, 32'h0);
    repeat (16) tick();
    check_output("late_access16_penable", 32'(bus.PENABLE), 32'd1);
    check_output("late_access16_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    bus.PREADY = 1'b1;
    tick();
    check_output("late_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check_output("late_rsp_err", 32'(bus.rsp_err), 32'd0);
    check_output("late_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    check_output("late_rsp_rdata", bus.rsp_rdata, 32'h5A5A_5A5A);
    finish_response();

    // Misaligned address never reaches the bus.
    apply_stimulus(1'b0, 32'h0000_0002, 32'h0);
    check_output("mis_psel", 32'(bus.PSEL), 32'd0);
    check_output("mis_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check_output("mis_rsp_err", 32'(bus.rsp_err), 32'd1);
    check_output("mis_rsp_rdata", bus.rsp_rdata, 32'h0);
    finish_response();

    // Reset pulse in the middle of an access.
    bus.PREADY = 1'b0;
    apply_stimulus(1'b0, 32'h0000_0030, 32'h0);
    tick();
    check_output("rst_pre_penable", 32'(bus.PENABLE), 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    check_output("rst_async_psel", 32'(bus.PSEL), 32'd0);
    check_output("rst_async_penable", 32'(bus.PENABLE), 32'd0);
    check_output("rst_async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("rst_async_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    #2 PRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    // Next command completes; response held for five cycles without rsp_ready.
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h1234_5678;
    apply_stimulus(1'b0, 32'h0000_0044, 32'h0);
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      check_output("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_output("hold_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
      check_output("hold_rsp_err", 32'(bus.rsp_err), 32'd0);
      bus.PRDATA = 32'hFFFF_0000 + 32'(i);
      tick();
    end
    check_output("hold_final_rdata", bus.rsp_rdata, 32'h1234_5678);
    finish_response();

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, 32, APB address width.
REQ-002 Parameter DATA_WIDTH, 32, APB data width.
REQ-003 Parameter TIMEOUT_CYCLES, 16, max consecutive ACCESS cycles with PREADY low before abort (>=2).
REQ-004 PCLK  input  1  sole clock, all logic on rising edge.
REQ-005 PRESETn  input  1  asynchronous active-low reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  bridge can accept a command.
REQ-008 cmd_write  input  1  1=write, 0=read.
REQ-009 cmd_addr  input  ADDR_WIDTH  target byte address.
REQ-010 cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumer ready.
REQ-013 rsp_rdata  output  DATA_WIDTH  read data, 0 for writes and errors.
REQ-014 rsp_err  output  1  PSLVERR, misalignment or timeout.
REQ-015 rsp_timeout  output  1  response terminated by timeout.
REQ-016 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-017 PADDR  output  ADDR_WIDTH; PWDATA  output  DATA_WIDTH.
REQ-018 PRDATA  input  DATA_WIDTH; PREADY  input  1; PSLVERR  input  1.

Function
REQ-019 FSM states IDLE, SETUP, ACCESS, RESP; all outputs registered except cmd_ready, which SHALL be 1 exactly when state==IDLE.
REQ-020 IDLE: on cmd_valid&&cmd_ready, latch write/addr/wdata into PWRITE/PADDR/PWDATA; aligned address (cmd_addr[1:0]==0) -> SETUP, else -> RESP with rsp_err=1, rsp_rdata=0, no APB activity.
REQ-021 SETUP: PSEL=1, PENABLE=0, exactly one cycle, then ACCESS.
REQ-022 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA stable from SETUP until transfer ends.
REQ-023 ACCESS with PREADY=1: capture PRDATA (reads only, else 0) into rsp_rdata and PSLVERR into rsp_err; next cycle PSEL=PENABLE=0, state RESP.
REQ-024 Wait counter clears on SETUP entry, increments each ACCESS cycle with PREADY=0; on reaching TIMEOUT_CYCLES: drop PSEL/PENABLE, rsp_err=1, rsp_timeout=1, rsp_rdata=0, state RESP.
REQ-025 PREADY=1 in the cycle the counter would reach TIMEOUT_CYCLES SHALL complete normally (PREADY wins).
REQ-026 RESP: rsp_valid=1, payload stable until rsp_ready=1; the handshake cycle returns to IDLE and clears rsp_valid, rsp_err, rsp_timeout.
REQ-027 Zero-wait latency: accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3; minimum command spacing 4 cycles (one outstanding).
REQ-028 PADDR/PWDATA/PWRITE hold last value in IDLE/RESP; PSEL/PENABLE SHALL be 0 outside SETUP/ACCESS.
REQ-029 cmd_valid while not in IDLE is ignored (not lost: held by requester per valid/ready).

Reset
REQ-030 PRESETn low SHALL asynchronously force state IDLE, all outputs 0 (cmd_ready=1 after reset release), counter 0.
REQ-031 Reset during SETUP/ACCESS/RESP SHALL drop PSEL/PENABLE/rsp_valid immediately; the in-flight command is discarded with no response.

Structure
REQ-032 Shared package apb_pkg SHALL hold the FSM state enum typedef and default width/timeout constants.
REQ-033 No sub-module is natural; FSM, counter and datapath registers live in this module.

Verification
REQ-034 Read 0x0000_0004, slave PREADY=1, PRDATA=0x0000_00A5 -> PSEL at N+1, PENABLE N+2, rsp_valid N+3, rsp_rdata=0xA5, rsp_err=0.
REQ-035 Write 0x0000_0008 data 0x05, PREADY low 3 ACCESS cycles -> PSEL/PENABLE held 4 ACCESS cycles, PWDATA=0x05 stable, rsp_rdata=0, rsp_err=0.
REQ-036 Read 0x1000_0010, PSLVERR=1 with PREADY -> rsp_err=1, rsp_timeout=0.
REQ-037 PREADY stuck 0, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_timeout=1, PSEL=0.
REQ-038 Command addr 0x0000_0002 -> PSEL never asserts, rsp_valid 1 cycle after accept, rsp_err=1.
REQ-039 PRESETn pulsed low during ACCESS -> PSEL/PENABLE 0 same cycle, no rsp_valid, next command completes normally; rsp_ready held 0 for 5 cycles -> payload stable throughout.
